exec_sequencer: RTL and testbench
=================================

// Module: exec_sequencer
// PURPOSE
//  Multi-cycle controller that sequences the Execute unit (ALU stage: ir/t1/t2/carry in, out_t1 result).
//  Accepts one operation per valid/ready handshake, decodes the opcode and clears the Execute unit.
//  Drives operands for a fixed settle window, captures out_t1 and presents the result with backpressure.
//  Sits between instruction issue and register write-back; it is the sole driver of the Execute inputs.
// PARAMETERS
//  p_data_width   16  width of ir, operands, result
//  p_exec_latency 3   cycles Execute inputs are held before out_t1 is sampled (>=1)
// PORTS
//  i_w_clk       in   1    clock; all state changes on rising edge
//  i_w_reset     in   1    synchronous, active-high reset
//  i_valid       in   1    request valid
//  o_ready       out  1    request accepted when i_valid & o_ready
//  i_ir          in   W    instruction word
//  i_op_a        in   W    operand for T1
//  i_op_b        in   W    operand for T2
//  i_carry       in   1    carry flag for ADC
//  o_ex_clr      out  1    active-high clear pulse to Execute (invert at instance if needed)
//  o_ex_ir       out  W    to Execute i_ir
//  o_ex_t1       out  W    to Execute i_t1
//  o_ex_t2       out  W    to Execute i_t2
//  o_ex_carry    out  1    to Execute i_w_carry
//  i_ex_t1       in   W    from Execute out_t1
//  o_res_valid   out  1    result valid
//  i_res_ready   in   1    result consumed when o_res_valid & i_res_ready
//  o_res         out  W    captured result
//  o_illegal     out  1    qualifies o_res_valid: opcode not supported
//  o_busy        out  1    high in every state except IDLE
// BEHAVIOUR
//  Opcode = ir[6:0]: ADC 1001010, AND 0011010, OR 1011010 (binary); SHL 0011000, SHR 1011000, SAR 0111000 (unary).
//  FSM states IDLE, CLR, RUN, CAP, RESP.
//  - IDLE: o_ready=1. On accept, latch ir/a/b/carry. Legal opcode -> CLR. Illegal -> RESP with o_illegal=1, o_res=0.
//  - CLR: o_ex_clr=1 for exactly one cycle; operands already driven. Next state RUN, counter loaded with p_exec_latency-1.
//  - RUN: counter decrements each cycle; at 0 -> CAP.
//  - CAP: o_res <= i_ex_t1 (one cycle) -> RESP.
//  - RESP: o_res_valid=1; o_res and o_illegal are held stable until i_res_ready. On handshake -> IDLE.
//  Latency: accept edge to o_res_valid high = p_exec_latency+2 cycles (legal op); 1 cycle for an illegal op.
//  o_ex_ir/t1 hold the latched values from CLR through CAP. o_ex_t2 is forced 0 for unary ops.
//  o_ex_carry = latched carry for ADC, else 0. Outside CLR..CAP all o_ex_* are 0, except o_ex_clr.
//  o_ready is 0 in RESP even when i_res_ready=1; no same-cycle turnaround, next accept occurs in IDLE.
//  Inputs that change while o_busy=1 are ignored.
//  Reset (any state, incl. mid-RUN): next state IDLE, counter 0, o_res=0, o_res_valid=0, o_illegal=0,
//  o_ex_*=0, o_ex_clr=0, o_busy=0, o_ready=1 on the first cycle after reset deasserts.
//  Width: counter is $clog2(p_exec_latency+1) bits; no arithmetic is done on data, which passes at W bits.
// STRUCTURE
//  Package exec_pkg: opcode localparams (OP_ADC..OP_SAR), opcode field width 7, FSM state encoding.
//  Sub-module exec_op_decode (combinational): ir -> {legal, unary, uses_carry}.
//  FSM, counter and output registers are in this module; Execute is instantiated by the parent.
// TESTING (bench instantiates exec_sequencer + Execute, p_exec_latency=3)
//  ADC a=000A b=0003 carry=1 -> o_res=000E, o_illegal=0, o_res_valid 5 cycles after accept.
//  AND a=00FF b=0F0F -> 000F; OR a=F0F0 b=0F0F -> FFFF; o_ex_carry=0 throughout both.
//  SHL a=0001 b=FFFF -> 0002 with o_ex_t2=0; SHR a=0002 -> 0001; SAR a=8000 -> C000.
//  ir=0007 -> o_illegal=1, o_res=0000, o_res_valid 1 cycle after accept, Execute never cleared.
//  Hold i_res_ready=0 for 4 cycles in RESP -> o_res/o_res_valid stable, o_ready=0, second i_valid not accepted.
//  Assert i_w_reset in the 2nd RUN cycle -> next cycle IDLE, all outputs at reset values; new ADC then completes correctly.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared opcode constants, FSM encoding and decode result type for the
// Execute sequencer.
package exec_pkg;

  localparam int OPC_W = 7;

  localparam logic [OPC_W-1:0] OP_ADC = 7'b1001010;
  localparam logic [OPC_W-1:0] OP_AND = 7'b0011010;
  localparam logic [OPC_W-1:0] OP_OR  = 7'b1011010;
  localparam logic [OPC_W-1:0] OP_SHL = 7'b0011000;
  localparam logic [OPC_W-1:0] OP_SHR = 7'b1011000;
  localparam logic [OPC_W-1:0] OP_SAR = 7'b0111000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_RUN  = 3'd2,
    ST_CAP  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  typedef struct packed {
    logic legal;
    logic unary;
    logic uses_carry;
  } dec_t;

endpackage

// File: rtl/exec_op_decode.sv
// Opcode classifier: tells the sequencer whether an opcode is supported,
// whether it ignores T2 and whether it consumes the carry flag.
module exec_op_decode
  import exec_pkg::*;
(
  input  logic [OPC_W-1:0] opc,
  output dec_t             dec
);

  // Pure table lookup; anything not listed is illegal.
  always_comb begin
    dec = '0;
    case (opc)
      OP_ADC: dec = '{legal: 1'b1, unary: 1'b0, uses_carry: 1'b1};
      OP_AND: dec = '{legal: 1'b1, unary: 1'b0, uses_carry: 1'b0};
      OP_OR:  dec = '{legal: 1'b1, unary: 1'b0, uses_carry: 1'b0};
      OP_SHL: dec = '{legal: 1'b1, unary: 1'b1, uses_carry: 1'b0};
      OP_SHR: dec = '{legal: 1'b1, unary: 1'b1, uses_carry: 1'b0};
      OP_SAR: dec = '{legal: 1'b1, unary: 1'b1, uses_carry: 1'b0};
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle controller for the Execute unit: accepts one op, clears
// Execute, holds operands for a settle window, captures out_t1 and returns
// it with backpressure. Illegal opcodes bypass Execute entirely.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int p_data_width   = 16,
  parameter int p_exec_latency = 3
) (
  input  logic                    i_w_clk,
  input  logic                    i_w_reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [p_data_width-1:0] i_ir,
  input  logic [p_data_width-1:0] i_op_a,
  input  logic [p_data_width-1:0] i_op_b,
  input  logic                    i_carry,
  output logic                    o_ex_clr,
  output logic [p_data_width-1:0] o_ex_ir,
  output logic [p_data_width-1:0] o_ex_t1,
  output logic [p_data_width-1:0] o_ex_t2,
  output logic                    o_ex_carry,
  input  logic [p_data_width-1:0] i_ex_t1,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic [p_data_width-1:0] o_res,
  output logic                    o_illegal,
  output logic                    o_busy
);

  localparam int W     = p_data_width;
  localparam int CNT_W = $clog2(p_exec_latency + 1);
  // CLR counts as the first settle cycle, so RUN covers the remaining ones.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(p_exec_latency - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef struct packed {
    logic [W-1:0] ir;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry;
    logic         unary;
    logic         uses_carry;
  } req_t;

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  req_t             req;
  dec_t             dec;
  logic             accept;
  logic             ex_on;

  exec_op_decode u_dec (
    .opc (i_ir[OPC_W-1:0]),
    .dec (dec)
  );

  // State, counter, latched request and result registers.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req       <= '0;
      o_res     <= '0;
      o_illegal <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        req       <= '{ir: i_ir, a: i_op_a, b: i_op_b, carry: i_carry,
                       unary: dec.unary, uses_carry: dec.uses_carry};
        o_illegal <= ~dec.legal;
        o_res     <= '0;
      end
      if (state == ST_CAP) o_res <= i_ex_t1;
    end
  end

  // Next state, counter update and handshake/control outputs.
  always_comb begin
    nxt         = state;
    cnt_nxt     = cnt;
    accept      = 1'b0;
    o_ready     = 1'b0;
    o_busy      = 1'b1;
    o_res_valid = 1'b0;
    o_ex_clr    = 1'b0;
    ex_on       = 1'b0;
    case (state)
      ST_IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
        if (i_valid) begin
          accept = 1'b1;
          nxt    = dec.legal ? ST_CLR : ST_RESP;
        end
      end
      ST_CLR: begin
        o_ex_clr = 1'b1;
        ex_on    = 1'b1;
        cnt_nxt  = CNT_LOAD;
        nxt      = (p_exec_latency == 1) ? ST_CAP : ST_RUN;
      end
      ST_RUN: begin
        ex_on   = 1'b1;
        cnt_nxt = cnt - CNT_ONE;
        // Leave as the counter reaches zero.
        if (cnt <= CNT_ONE) nxt = ST_CAP;
      end
      ST_CAP: begin
        ex_on = 1'b1;
        nxt   = ST_RESP;
      end
      ST_RESP: begin
        o_res_valid = 1'b1;
        if (i_res_ready) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Execute operands are only non-zero from CLR through CAP.
  always_comb begin
    o_ex_ir    = ex_on ? req.ir : '0;
    o_ex_t1    = ex_on ? req.a : '0;
    o_ex_t2    = (ex_on && !req.unary) ? req.b : '0;
    o_ex_carry = ex_on & req.uses_carry & req.carry;
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a behavioural Execute unit and a
// cycle-offset model of what the sequencer must present on every cycle.
module tb_exec_sequencer;

  localparam int W = 16;
  localparam int L = 3;

  logic         clk = 1'b0;
  logic         i_w_reset, i_valid, i_carry, i_res_ready;
  logic [W-1:0] i_ir, i_op_a, i_op_b;
  logic         o_ready, o_ex_clr, o_ex_carry, o_res_valid, o_illegal, o_busy;
  logic [W-1:0] o_ex_ir, o_ex_t1, o_ex_t2, o_res;
  logic [W-1:0] ex_out;

  int n_chk = 0;
  int n_err = 0;
  int clr_cnt = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  exec_sequencer #(.p_data_width(W), .p_exec_latency(L)) dut (
    .i_w_clk(clk), .i_w_reset(i_w_reset),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_ir(i_ir), .i_op_a(i_op_a), .i_op_b(i_op_b), .i_carry(i_carry),
    .o_ex_clr(o_ex_clr), .o_ex_ir(o_ex_ir), .o_ex_t1(o_ex_t1),
    .o_ex_t2(o_ex_t2), .o_ex_carry(o_ex_carry), .i_ex_t1(ex_out),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res(o_res), .o_illegal(o_illegal), .o_busy(o_busy)
  );

  function automatic logic [W-1:0] alu(input logic [W-1:0] ir, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic c);
    logic [6:0] op;
    op = ir[6:0];
    case (op)
      7'h4A:   return a + b + W'(c);
      7'h1A:   return a & b;
      7'h5A:   return a | b;
      7'h18:   return a << 1;
      7'h58:   return a >> 1;
      7'h38:   return {a[W-1], a[W-1:1]};
      default: return '0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [W-1:0] ir);
    logic [6:0] op;
    op = ir[6:0];
    return op inside {7'h4A, 7'h1A, 7'h5A, 7'h18, 7'h58, 7'h38};
  endfunction

  function automatic bit is_unary(input logic [W-1:0] ir);
    logic [6:0] op;
    op = ir[6:0];
    return op inside {7'h18, 7'h58, 7'h38};
  endfunction

  // Behavioural Execute: clear wins, otherwise computes from its inputs each cycle.
  always @(posedge clk) begin
    if (o_ex_clr) ex_out <= '0;
    else          ex_out <= alu(o_ex_ir, o_ex_t1, o_ex_t2, o_ex_carry);
  end

  always @(negedge clk) if (o_ex_clr) clr_cnt <= clr_cnt + 1;

  // Model: m_k is the cycle index after the accepting edge (1 = first cycle).
  bit           m_active = 0;
  int           m_k = 0;
  logic [W-1:0] m_ir, m_a, m_b;
  logic         m_c;
  logic         m_legal, exp_win, exp_resp;

  assign m_legal  = is_legal(m_ir);
  assign exp_win  = m_active && m_legal && (m_k <= L + 1);
  assign exp_resp = m_active && (m_legal ? (m_k >= L + 2) : 1'b1);

  always @(posedge clk) begin
    if (i_w_reset) begin
      m_active <= 0;
      m_k      <= 0;
    end else if (!m_active) begin
      if (i_valid) begin
        m_active <= 1;
        m_k      <= 1;
        m_ir     <= i_ir;
        m_a      <= i_op_a;
        m_b      <= i_op_b;
        m_c      <= i_carry;
      end
    end else if (exp_resp && i_res_ready) begin
      m_active <= 0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(o_ready), 32'(!m_active));
      check("busy", 32'(o_busy), 32'(m_active));
      check("res_valid", 32'(o_res_valid), 32'(exp_resp));
      check("ex_clr", 32'(o_ex_clr), 32'(exp_win && m_k == 1));
      check("ex_ir", 32'(o_ex_ir), exp_win ? 32'(m_ir) : 32'd0);
      check("ex_t1", 32'(o_ex_t1), exp_win ? 32'(m_a) : 32'd0);
      check("ex_t2", 32'(o_ex_t2), (exp_win && !is_unary(m_ir)) ? 32'(m_b) : 32'd0);
      check("ex_carry", 32'(o_ex_carry),
            (exp_win && m_ir[6:0] == 7'h4A) ? 32'(m_c) : 32'd0);
      if (exp_resp) begin
        check("res", 32'(o_res), m_legal ? 32'(alu(m_ir, m_a, m_b, m_c)) : 32'd0);
        check("illegal", 32'(o_illegal), 32'(!m_legal));
      end
    end
  end

  task automatic run_op(input string name, input logic [W-1:0] ir, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c, input logic [W-1:0] exp_res,
                        input logic exp_ill, input int exp_lat);
    int n;
    i_ir = ir; i_op_a = a; i_op_b = b; i_carry = c; i_valid = 1;
    @(posedge clk); #1;
    // Scramble inputs while busy; the DUT must keep its latched copy.
    i_valid = 0; i_ir = ~ir; i_op_a = ~a; i_op_b = ~b; i_carry = ~c;
    n = 1;
    while (!o_res_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    check({name, " result"}, 32'(o_res), 32'(exp_res));
    check({name, " illegal"}, 32'(o_illegal), 32'(exp_ill));
    i_res_ready = 1;
    @(posedge clk); #1;
    i_res_ready = 0;
  endtask

  initial begin
    int clr0;
    int n;
    i_w_reset = 1; i_valid = 0; i_res_ready = 0;
    i_ir = '0; i_op_a = '0; i_op_b = '0; i_carry = 0;
    repeat (2) @(posedge clk);
    #1;
    i_w_reset = 0;
    chk_en = 1;
    check("reset ready", 32'(o_ready), 32'd1);
    check("reset busy", 32'(o_busy), 32'd0);
    check("reset res_valid", 32'(o_res_valid), 32'd0);
    check("reset res", 32'(o_res), 32'd0);

    run_op("adc", 16'h004A, 16'h000A, 16'h0003, 1'b1, 16'h000E, 1'b0, L + 2);
    run_op("and", 16'h001A, 16'h00FF, 16'h0F0F, 1'b1, 16'h000F, 1'b0, L + 2);
    run_op("or",  16'h005A, 16'hF0F0, 16'h0F0F, 1'b1, 16'hFFFF, 1'b0, L + 2);
    run_op("shl", 16'h0018, 16'h0001, 16'hFFFF, 1'b0, 16'h0002, 1'b0, L + 2);
    run_op("shr", 16'h0058, 16'h0002, 16'hFFFF, 1'b0, 16'h0001, 1'b0, L + 2);
    run_op("sar", 16'h0038, 16'h8000, 16'h1234, 1'b0, 16'hC000, 1'b0, L + 2);

    clr0 = clr_cnt;
    run_op("illegal", 16'h0007, 16'h1111, 16'h2222, 1'b1, 16'h0000, 1'b1, 1);
    check("illegal no clear", 32'(clr_cnt), 32'(clr0));

    // Backpressure: result must hold while a second request waits unaccepted.
    i_ir = 16'h004A; i_op_a = 16'h000A; i_op_b = 16'h0003; i_carry = 1; i_valid = 1;
    @(posedge clk); #1;
    i_ir = 16'h001A; i_op_a = 16'hFFFF; i_op_b = 16'hFFFF;
    n = 1;
    while (!o_res_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      check("bp res", 32'(o_res), 32'h000E);
      check("bp valid", 32'(o_res_valid), 32'd1);
      check("bp ready", 32'(o_ready), 32'd0);
      @(posedge clk); #1;
    end
    i_valid = 0; i_res_ready = 1;
    @(posedge clk); #1;
    i_res_ready = 0;
    check("bp second not taken", 32'(o_busy), 32'd0);

    // Reset during the second RUN cycle.
    i_ir = 16'h004A; i_op_a = 16'h0100; i_op_b = 16'h0020; i_carry = 0; i_valid = 1;
    @(posedge clk); #1;
    i_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_w_reset = 1;
    @(posedge clk); #1;
    i_w_reset = 0;
    check("rst ready", 32'(o_ready), 32'd1);
    check("rst busy", 32'(o_busy), 32'd0);
    check("rst res", 32'(o_res), 32'd0);
    check("rst illegal", 32'(o_illegal), 32'd0);
    check("rst ex", {o_ex_clr, o_ex_carry, 30'(o_ex_ir | o_ex_t1 | o_ex_t2)}, 32'd0);
    run_op("adc after reset", 16'h004A, 16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0, L + 2);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
